// File: rtl/watch_pkg.sv
// Shared types and constants for the stopwatch controller: FSM encoding,
// BCD digit limits, display positions and the digit-select helper.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX9 = 4'd9;
  localparam logic [3:0] BCD_MAX5 = 4'd5;

  localparam logic [1:0] POS_CS_ONES  = 2'd0;
  localparam logic [1:0] POS_CS_TENS  = 2'd1;
  localparam logic [1:0] POS_SEC_ONES = 2'd2;
  localparam logic [1:0] POS_SEC_TENS = 2'd3;

  typedef struct packed {
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] cs_tens;
    logic [3:0] cs_ones;
  } bcd_time_t;

  function automatic logic [3:0] pick_digit(input bcd_time_t t, input logic [1:0] pos);
    logic [3:0] d;
    case (pos)
      POS_CS_ONES:  d = t.cs_ones;
      POS_CS_TENS:  d = t.cs_tens;
      POS_SEC_ONES: d = t.sec_ones;
      POS_SEC_TENS: d = t.sec_tens;
      default:      d = 4'd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/bcd_cnt.sv
// Single BCD digit counter with a programmable maximum; carry is high when
// the digit is enabled while sitting at its maximum (it rolls to zero).
module bcd_cnt
  import watch_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_r;

  // digit register: reset/clear to zero, step on enable
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= 4'd0;
    end else if (clr) begin
      q_r <= 4'd0;
    end else if (en) begin
      if (q_r == MAX) begin
        q_r <= 4'd0;
      end else begin
        q_r <= q_r + 4'd1;
      end
    end else begin
      q_r <= q_r;
    end
  end

  assign q     = q_r;
  assign carry = en & (q_r == MAX);

endmodule

// File: rtl/watch_ctrl.sv
// Stopwatch controller: start/stop/lap/clear FSM, 10 ms prescaler, SS.CC BCD
// time, lap latch and a 4-position multiplexed display driver.
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 500000,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_ss,
  input  logic       key_clr,
  input  logic       key_lap,
  output logic [1:0] sel,
  output logic [3:0] dig_val,
  output logic       dp_en,
  output logic       running,
  output logic       wrap
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_e        state_r;
  state_e        next_state_s;
  logic          clr_time_s;
  logic          lap_load_s;
  logic          counting_s;
  logic          tick_s;
  logic [TW-1:0] presc_r;
  logic [SW-1:0] scan_r;
  logic          scan_step_s;
  logic [1:0]    sel_r;
  logic [1:0]    sel_nxt_s;
  logic [3:0]    carry_s;
  bcd_time_t     live_s;
  bcd_time_t     lap_r;
  bcd_time_t     disp_s;
  logic [3:0]    dig_val_r;
  logic          dp_en_r;
  logic          running_r;
  logic          wrap_r;

  // key precedence is ss > lap > clr, expressed by the if/else order
  always_comb begin
    next_state_s = state_r;
    clr_time_s   = 1'b0;
    lap_load_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (key_ss) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (key_ss) begin
          next_state_s = ST_PAUSE;
        end else if (key_lap) begin
          next_state_s = ST_LAP;
          lap_load_s   = 1'b1;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_LAP: begin
        if (key_ss) begin
          next_state_s = ST_PAUSE;
        end else if (key_lap) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_LAP;
        end
      end
      ST_PAUSE: begin
        if (key_ss) begin
          next_state_s = ST_RUN;
        end else if (key_clr) begin
          next_state_s = ST_IDLE;
          clr_time_s   = 1'b1;
        end else begin
          next_state_s = ST_PAUSE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  assign counting_s = (state_r == ST_RUN) || (state_r == ST_LAP);
  assign tick_s     = counting_s && (presc_r == TW'(TICK_DIV - 1));

  // tick prescaler, frozen outside RUN/LAP so PAUSE keeps its phase
  always_ff @(posedge clk) begin
    if (rst || clr_time_s) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else if (counting_s) begin
      presc_r <= presc_r + TW'(1);
    end else begin
      presc_r <= presc_r;
    end
  end

  bcd_cnt #(.MAX(BCD_MAX9)) u_cs_ones (
    .clk(clk), .rst(rst), .clr(clr_time_s), .en(tick_s),
    .q(live_s.cs_ones), .carry(carry_s[0])
  );
  bcd_cnt #(.MAX(BCD_MAX9)) u_cs_tens (
    .clk(clk), .rst(rst), .clr(clr_time_s), .en(carry_s[0]),
    .q(live_s.cs_tens), .carry(carry_s[1])
  );
  bcd_cnt #(.MAX(BCD_MAX9)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(clr_time_s), .en(carry_s[1]),
    .q(live_s.sec_ones), .carry(carry_s[2])
  );
  bcd_cnt #(.MAX(BCD_MAX5)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(clr_time_s), .en(carry_s[2]),
    .q(live_s.sec_tens), .carry(carry_s[3])
  );

  // lap latch captures the pre-tick live time
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_r <= '0;
    end else if (lap_load_s) begin
      lap_r <= live_s;
    end else begin
      lap_r <= lap_r;
    end
  end

  // free-running scan divider and position counter
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_r <= '0;
      sel_r  <= POS_CS_ONES;
    end else if (scan_step_s) begin
      scan_r <= '0;
      sel_r  <= sel_nxt_s;
    end else begin
      scan_r <= scan_r + SW'(1);
      sel_r  <= sel_r;
    end
  end

  assign scan_step_s = (scan_r == SW'(SCAN_DIV - 1));

  // digit is fetched for the upcoming sel so both land on the same edge
  always_comb begin
    if (scan_step_s) begin
      sel_nxt_s = sel_r + 2'd1;
    end else begin
      sel_nxt_s = sel_r;
    end
    if (state_r == ST_LAP) begin
      disp_s = lap_r;
    end else begin
      disp_s = live_s;
    end
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_val_r <= 4'd0;
      dp_en_r   <= 1'b0;
      running_r <= 1'b0;
      wrap_r    <= 1'b0;
    end else begin
      dig_val_r <= pick_digit(disp_s, sel_nxt_s);
      dp_en_r   <= (sel_nxt_s == POS_SEC_ONES);
      running_r <= (next_state_s == ST_RUN) || (next_state_s == ST_LAP);
      wrap_r    <= carry_s[3];
    end
  end

  assign sel     = sel_r;
  assign dig_val = dig_val_r;
  assign dp_en   = dp_en_r;
  assign running = running_r;
  assign wrap    = wrap_r;

endmodule

// File: tb/tb_watch_ctrl.sv
// Bench for watch_ctrl: integer-centisecond reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_watch_ctrl;

  localparam int TD = 4;
  localparam int SD = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_ss = 1'b0;
  logic       key_clr = 1'b0;
  logic       key_lap = 1'b0;
  logic [1:0] sel;
  logic [3:0] dig_val;
  logic       dp_en;
  logic       running;
  logic       wrap;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  watch_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .key_ss(key_ss), .key_clr(key_clr), .key_lap(key_lap),
    .sel(sel), .dig_val(dig_val), .dp_en(dp_en), .running(running), .wrap(wrap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int digit(input int v, input int p);
    case (p)
      0:       return v % 10;
      1:       return (v / 10) % 10;
      2:       return (v / 100) % 10;
      default: return v / 1000;
    endcase
  endfunction

  // reference model: time held as integer centiseconds (SS*100 + CC)
  int m_st, m_presc, m_time, m_lap, m_scan, m_sel, m_dig, m_dp, m_run, m_wrap;
  bit m_valid = 1'b0;

  always @(posedge clk) begin : model
    int  disp, nst;
    bit  tick, clr, load, cnt;
    if (rst) begin
      m_st = M_IDLE; m_presc = 0; m_time = 0; m_lap = 0; m_scan = 0;
      m_sel = 0; m_dig = 0; m_dp = 0; m_run = 0; m_wrap = 0;
    end else begin
      cnt  = (m_st == M_RUN) || (m_st == M_LAP);
      tick = cnt && (m_presc == TD - 1);
      disp = (m_st == M_LAP) ? m_lap : m_time;
      nst = m_st; clr = 0; load = 0;
      if (m_st == M_IDLE) begin
        if (key_ss) nst = M_RUN;
      end else if (m_st == M_RUN) begin
        if (key_ss) nst = M_PAUSE;
        else if (key_lap) begin nst = M_LAP; load = 1; end
      end else if (m_st == M_LAP) begin
        if (key_ss) nst = M_PAUSE;
        else if (key_lap) nst = M_RUN;
      end else begin
        if (key_ss) nst = M_RUN;
        else if (key_clr) begin nst = M_IDLE; clr = 1; end
      end
      if (load) m_lap = m_time;
      m_wrap = (tick && m_time == 5999) ? 1 : 0;
      if (clr) begin
        m_time = 0; m_presc = 0;
      end else if (cnt) begin
        m_presc = tick ? 0 : m_presc + 1;
        if (tick) m_time = (m_time + 1) % 6000;
      end
      if (m_scan == SD - 1) begin
        m_scan = 0; m_sel = (m_sel + 1) % 4;
      end else begin
        m_scan = m_scan + 1;
      end
      m_dig = digit(disp, m_sel);
      m_dp  = (m_sel == 2) ? 1 : 0;
      m_run = (nst == M_RUN || nst == M_LAP) ? 1 : 0;
      m_st  = nst;
    end
    m_valid = 1'b1;
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("sel", 32'(sel), 32'(m_sel));
      check("dig_val", 32'(dig_val), 32'(m_dig));
      check("dp_en", 32'(dp_en), 32'(m_dp));
      check("running", 32'(running), 32'(m_run));
      check("wrap", 32'(wrap), 32'(m_wrap));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit ss, input bit clr_k, input bit lap);
    key_ss = ss; key_clr = clr_k; key_lap = lap;
    @(posedge clk);
    #1;
    key_ss = 1'b0; key_clr = 1'b0; key_lap = 1'b0;
  endtask

  // collects one full scan; returns {sec_tens, sec_ones, cs_tens, cs_ones}
  task automatic read_display(output logic [15:0] v);
    v = 16'h0000;
    repeat (8) begin
      @(negedge clk);
      v[sel*4 +: 4] = dig_val;
    end
    @(posedge clk);
    #1;
  endtask

  logic [15:0] d;

  initial begin
    step(3);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_dig", 32'(dig_val), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    rst = 1'b0;

    // run 400 cycles -> 01.00
    pulse(1'b1, 1'b0, 1'b0);
    step(400);
    check("t_100", 32'(m_time), 32'd100);
    check("run_400", 32'(running), 32'd1);
    pulse(1'b1, 1'b0, 1'b0);
    read_display(d);
    check("disp_0100", 32'(d), 32'h0100);
    pulse(1'b0, 1'b1, 1'b0);
    check("clr_time", 32'(m_time), 32'd0);
    check("clr_running", 32'(running), 32'd0);

    // pause holds time and prescaler phase
    pulse(1'b1, 1'b0, 1'b0);
    step(40);
    pulse(1'b1, 1'b0, 1'b0);
    step(40);
    check("pause_t10", 32'(m_time), 32'd10);
    read_display(d);
    check("disp_0010", 32'(d), 32'h0010);
    pulse(1'b1, 1'b0, 1'b0);
    step(2);
    check("phase_hold", 32'(m_time), 32'd10);
    step(1);
    check("phase_tick", 32'(m_time), 32'd11);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);

    // lap freeze at 00.05 while live reaches 00.25
    pulse(1'b1, 1'b0, 1'b0);
    step(20);
    pulse(1'b0, 1'b0, 1'b1);
    read_display(d);
    check("lap_0005", 32'(d), 32'h0005);
    step(72);
    check("live_25", 32'(m_time), 32'd25);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    read_display(d);
    check("disp_0025", 32'(d), 32'h0025);

    // ss beats clr in PAUSE; lap beats clr in RUN and latches pre-tick time
    pulse(1'b1, 1'b1, 1'b0);
    check("ss_clr_time", 32'(m_time), 32'd25);
    check("ss_clr_run", 32'(running), 32'd1);
    pulse(1'b0, 1'b1, 1'b1);
    check("lap_tick_live", 32'(m_time), 32'd26);
    read_display(d);
    check("lap_pretick", 32'(d), 32'h0025);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("idle_time", 32'(m_time), 32'd0);
    check("idle_running", 32'(running), 32'd0);
    read_display(d);
    check("disp_0000", 32'(d), 32'h0000);

    // wrap 59.99 -> 00.00
    pulse(1'b1, 1'b0, 1'b0);
    step(23998);
    pulse(1'b1, 1'b0, 1'b0);
    check("t_5999", 32'(m_time), 32'd5999);
    read_display(d);
    check("disp_5999", 32'(d), 32'h5999);
    pulse(1'b1, 1'b0, 1'b0);
    check("wrap_pre", 32'(wrap), 32'd0);
    step(1);
    check("wrap_hi", 32'(wrap), 32'd1);
    check("wrap_time", 32'(m_time), 32'd0);
    step(1);
    check("wrap_lo", 32'(wrap), 32'd0);

    // reset mid-run at 12.34, coincident with a key
    step(4935);
    check("t_1234", 32'(m_time), 32'd1234);
    rst = 1'b1; key_ss = 1'b1;
    step(1);
    check("mr_sel", 32'(sel), 32'd0);
    check("mr_dig", 32'(dig_val), 32'd0);
    check("mr_dp", 32'(dp_en), 32'd0);
    check("mr_running", 32'(running), 32'd0);
    check("mr_wrap", 32'(wrap), 32'd0);
    rst = 1'b0; key_ss = 1'b0;
    step(2);
    check("key_discarded", 32'(running), 32'd0);
    pulse(1'b1, 1'b0, 1'b0);
    check("restart", 32'(running), 32'd1);
    step(4);
    check("restart_tick", 32'(m_time), 32'd1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
